uart_rx_fifo: RTL and testbench

- Byte buffer directly downstream of the 8N1 UART receiver.
- Converts the receiver's completion level (`rx_ready`) plus `rx_data` into one push per received byte, and stores the bytes in a circular FIFO.
- Presents the bytes first-word-fall-through to the PDU command logic, so that slow consumers do not lose bytes arriving back-to-back.
- Flags drops caused by a full buffer in a sticky overflow bit.

---
 rtl/uart_rx_fifo.sv | 96 +++++++++
 tb/tb_uart_rx_fifo.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : Byte FIFO behind the 8N1 UART receiver. Turns each rising edge
//             of rx_ready into one push and presents bytes first-word-fall-
//             through, with a sticky overflow flag for bytes dropped when full.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  rx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rd_en,
  output logic [7:0]            dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam logic [DEPTH_LOG2:0] c_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic                  r_prev_ready;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_wr_accept;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_DEPTH);

  // prev_ready resets high so a level already present at reset release is ignored
  assign w_push      = en & rx_ready & ~r_prev_ready;
  assign w_pop       = en & rd_en & ~w_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still fits
  assign w_wr_accept = w_push & (~w_full | w_pop);
  assign w_drop      = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_prev_ready <= 1'b1;
    end else begin
      r_prev_ready <= rx_ready;
      if (!en) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_wr_accept) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
        if (w_pop)       r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);

        if (w_wr_accept && !w_pop)
          r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
        else if (!w_wr_accept && w_pop)
          r_count <= r_count - (DEPTH_LOG2 + 1)'(1);

        // a drop in the same cycle as a clear keeps the flag set
        if (w_drop)
          r_overflow <= 1'b1;
        else if (clr_overflow)
          r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_accept) r_mem[r_wr_ptr] <= rx_data;
  end

  // Storage is not reset, so the head is masked to zero while nothing is held
  assign dout     = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// Testbench for uart_rx_fifo: directed scenarios plus a randomized run,
// all checked against a queue-based model of the byte buffer.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rd_en;
  logic       clr_overflow;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_prev;

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rd_en        (rd_en),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_prev = 1'b1;
  endtask

  // One clock edge; the model consumes the inputs present at that edge.
  task automatic tick();
    bit push, pop, drop;
    @(posedge clk);
    push = en && rx_ready && !m_prev;
    pop  = en && rd_en && (q.size() != 0);
    drop = 1'b0;
    if (!en) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (push && q.size() == 16 && !pop) drop = 1'b1;
      if (pop) void'(q.pop_front());
      if (push && !drop) q.push_back(rx_data);
      if (drop) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
    end
    m_prev = rx_ready;
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
  endtask

  task automatic pop_byte();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
    rd_en = 1'b0; clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags: count=%0d empty=%b full=%b, want 0/1/0", count, empty, full);
    end
    n_checks++;
    if (overflow !== 1'b0 || dout !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_out: overflow=%b dout=%h, want 0/00", overflow, dout);
    end
  endtask

  task automatic test_level_push();
    int bad = 0;
    en = 1'b1; rx_ready = 1'b0;
    tick();
    rx_data = 8'h41; rx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (count !== 5'd1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL level_push_count: count=%0d on %0d cycles, want 1 every cycle", count, bad);
    end
    n_checks++;
    if (dout !== 8'h41 || empty !== 1'b0) begin
      n_errors++;
      $display("FAIL level_push_data: dout=%h empty=%b, want 41/0", dout, empty);
    end
    rx_ready = 1'b0;
    tick();
    pop_byte();
  endtask

  task automatic test_fill_overflow();
    int bad = 0;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    n_checks++;
    if (full !== 1'b1 || count !== 5'd16) begin
      n_errors++;
      $display("FAIL fill_full: full=%b count=%0d, want 1/16", full, count);
    end
    push_byte(8'hAA);
    n_checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      n_errors++;
      $display("FAIL drop_when_full: overflow=%b count=%0d, want 1/16", overflow, count);
    end
    for (int i = 0; i < 16; i++) begin
      if (dout !== 8'(i)) begin
        bad++;
        $display("FAIL drain_order: got %h, want %h", dout, 8'(i));
      end
      pop_byte();
    end
    n_checks++;
    if (bad != 0) n_errors++;
    n_checks++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL drained: empty=%b overflow=%b, want 1/1", empty, overflow);
    end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_overflow: overflow=%b, want 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
    rx_data = 8'h55; rx_ready = 1'b1; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (count !== 5'd16 || overflow !== 1'b0 || dout !== 8'h21) begin
      n_errors++;
      $display("FAIL full_push_pop: count=%0d overflow=%b dout=%h, want 16/0/21", count, overflow, dout);
    end
    rx_ready = 1'b0;
    tick();
    repeat (15) pop_byte();
    n_checks++;
    if (dout !== 8'h55 || count !== 5'd1) begin
      n_errors++;
      $display("FAIL wrap_data: dout=%h count=%0d, want 55/1", dout, count);
    end
    pop_byte();
  endtask

  task automatic test_empty_push_pop();
    rx_data = 8'h7E; rx_ready = 1'b1; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (count !== 5'd1 || dout !== 8'h7E) begin
      n_errors++;
      $display("FAIL empty_push_pop: count=%0d dout=%h, want 1/7e", count, dout);
    end
    rx_ready = 1'b0;
    tick();
    pop_byte();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || dout !== 8'h00) begin
      n_errors++;
      $display("FAIL pop_on_empty: count=%0d empty=%b overflow=%b dout=%h, want 0/1/0/00",
               count, empty, overflow, dout);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push_byte(8'(8'h90 + i));
    en = 1'b0; rx_data = 8'h99; rx_ready = 1'b1;
    tick();
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL flush: count=%0d empty=%b overflow=%b, want 0/1/0", count, empty, overflow);
    end
    en = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (count !== 5'd0) begin
      n_errors++;
      $display("FAIL no_push_after_en: count=%0d, want 0", count);
    end
    rx_ready = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) push_byte(8'(8'hC0 + i));
    push_byte(8'hDD);
    repeat (13) pop_byte();
    n_checks++;
    if (count !== 5'd3 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_reset: count=%0d overflow=%b, want 3/1", count, overflow);
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || dout !== 8'h00) begin
      n_errors++;
      $display("FAIL async_reset: count=%0d empty=%b overflow=%b dout=%h, want 0/1/0/00",
               count, empty, overflow, dout);
    end
    #1 rst = 1'b0;
    model_reset();
    tick();
    for (int i = 0; i < 16; i++) push_byte(8'(i * 3));
    rx_data = 8'hEE; rx_ready = 1'b1; clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    n_checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      n_errors++;
      $display("FAIL set_beats_clear: overflow=%b count=%0d, want 1/16", overflow, count);
    end
    rx_ready = 1'b0;
    en = 1'b0;
    tick();
    en = 1'b1;
  endtask

  task automatic test_random();
    int bad = 0;
    int rd_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) rd_pct = $urandom_range(5, 90);
      en = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 2) == 0) begin
        if (!rx_ready) rx_data = 8'($urandom);
        rx_ready = ~rx_ready;
      end
      rd_en        = ($urandom_range(0, 99) < rd_pct);
      clr_overflow = ($urandom_range(0, 39) == 0);
      tick();
      if (int'(count) !== q.size() || empty !== (q.size() == 0) ||
          full !== (q.size() == 16) || overflow !== m_ovf ||
          (q.size() != 0 && dout !== q[0])) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random_cycle%0d: count=%0d empty=%b full=%b ovf=%b dout=%h, want %0d/%b/%h",
                   c, count, empty, full, overflow, dout, q.size(), m_ovf,
                   (q.size() != 0) ? q[0] : 8'h00);
      end
    end
    n_checks++;
    if (bad != 0) n_errors++;
    rd_en = 1'b0; clr_overflow = 1'b0; rx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_level_push();
    test_fill_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
